// File: rtl/split_linebuf_pkg.sv
// split_pkg: shared defaults and the rotated-bank index helper for split_linebuf
package split_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int MAX_ROW_LEN_DEF = 32;
  localparam int KERNEL_LENGTH_DEF = 3;
  function automatic int rot_idx(input int slot, input int i, input int nbanks);
    return (slot + i) % nbanks;
  endfunction
endpackage

// File: rtl/split_linebuf_if.sv
// split_linebuf_if: pixel input stream and column-vector output stream
interface split_linebuf_if import split_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int KERNEL_LENGTH = KERNEL_LENGTH_DEF
) ();
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/split_linebuf_bank.sv
// linebuf_bank: read-first simple dual-port row RAM whose read port holds when not enabled
module linebuf_bank import split_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = MAX_ROW_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic wen,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic ren,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout_d, dout_q;
  // read port returns the pre-write contents and otherwise keeps its last value
  always_comb dout_d = ren ? mem[raddr] : dout_q;
  // storage write
  always_ff @(posedge clk) if (wen) mem[waddr] <= wdata;
  // read register
  always_ff @(posedge clk) dout_q <= rst ? '0 : dout_d;
  assign dout = dout_q;
endmodule

// File: rtl/split_linebuf.sv
// split_linebuf: rotating row buffer emitting one KERNEL_LENGTH-tall column per accepted pixel
module split_linebuf import split_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_ROW_LEN = MAX_ROW_LEN_DEF,
  parameter int KERNEL_LENGTH = KERNEL_LENGTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic [$clog2(MAX_ROW_LEN+1)-1:0] cfg_row_len,
  split_linebuf_if.slave bus,
  output logic full_flag,
  output logic empty_flag
);
  localparam int NB = KERNEL_LENGTH - 1;
  localparam int CW = $clog2(MAX_ROW_LEN);
  localparam int LW = $clog2(MAX_ROW_LEN + 1);
  localparam int SW = $clog2(KERNEL_LENGTH);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  logic [CW-1:0] col_d, col_q;
  logic [LW-1:0] row_len_d, row_len_q, cfg_norm;
  logic [SW-1:0] rows_filled_d, rows_filled_q, wr_slot_d, wr_slot_q, rd_slot_d, rd_slot_q;
  logic out_valid_d, out_valid_q, out_last_d, out_last_q;
  logic [DATA_WIDTH-1:0] top_d, top_q;
  logic [DATA_WIDTH-1:0] bank_dout [2**BW];
  logic accept, last_col, primed;
  assign bus.in_ready = !rst && !clear && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign last_col = LW'(col_q) == row_len_q - LW'(1);
  assign primed = rows_filled_q == SW'(NB);
  assign cfg_norm = (cfg_row_len == '0 || cfg_row_len > LW'(MAX_ROW_LEN)) ? LW'(MAX_ROW_LEN) : cfg_row_len;
  // column/row bookkeeping and output staging for the next cycle
  always_comb begin
    col_d = clear ? '0 : accept ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    row_len_d = clear ? cfg_norm : row_len_q;
    wr_slot_d = clear ? '0 : (accept && last_col) ? (wr_slot_q == SW'(NB - 1) ? '0 : wr_slot_q + SW'(1)) : wr_slot_q;
    rows_filled_d = clear ? '0 : (accept && last_col && !primed) ? rows_filled_q + SW'(1) : rows_filled_q;
    rd_slot_d = accept ? wr_slot_q : rd_slot_q;
    top_d = accept ? bus.in_data : top_q;
    out_valid_d = clear ? 1'b0 : accept ? primed : bus.out_ready ? 1'b0 : out_valid_q;
    out_last_d = clear ? 1'b0 : accept ? last_col : out_last_q;
  end
  // state registers; reset also latches the configured row length
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_len_q <= cfg_norm;
      wr_slot_q <= '0;
      rows_filled_q <= '0;
      rd_slot_q <= '0;
      top_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_len_q <= row_len_d;
      wr_slot_q <= wr_slot_d;
      rows_filled_q <= rows_filled_d;
      rd_slot_q <= rd_slot_d;
      top_q <= top_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
    end
  end
  for (genvar g = 0; g < NB; g++) begin : g_bank
    linebuf_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_ROW_LEN)) u_bank (
      .clk(clk),
      .rst(rst),
      .wen(accept && wr_slot_q == SW'(g)),
      .waddr(col_q),
      .wdata(bus.in_data),
      .ren(accept),
      .raddr(col_q),
      .dout(bank_dout[g])
    );
  end
  for (genvar g = NB; g < 2**BW; g++) begin : g_pad
    assign bank_dout[g] = '0;
  end
  for (genvar i = 0; i < NB; i++) begin : g_col
    assign bus.out_data[i] = bank_dout[BW'(rot_idx(int'(rd_slot_q), i, NB))];
  end
  assign bus.out_data[KERNEL_LENGTH-1] = top_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last = out_last_q;
  assign full_flag = primed;
  assign empty_flag = rows_filled_q == '0 && col_q == '0;
endmodule

// File: tb/tb_split_linebuf.sv
// tb_split_linebuf: directed and random stream checks against a frame-history model
module tb_split_linebuf;
  localparam int DW = 32, ML = 32, KL = 3, ML2 = 8, KL2 = 5;
  logic clk = 0, rst = 1, clear = 0, clear2 = 0;
  logic [5:0] cfg = 6'd32;
  logic [3:0] cfg2 = 4'd0;
  logic full, empty, full2, empty2;
  int errors = 0, checks = 0;
  logic [DW-1:0] frame [$];
  int row_len;
  logic exp_ov, exp_last, exp_zero;
  logic [KL-1:0][DW-1:0] exp_vec;
  split_linebuf_if #(.DATA_WIDTH(DW), .KERNEL_LENGTH(KL)) bus ();
  split_linebuf_if #(.DATA_WIDTH(DW), .KERNEL_LENGTH(KL2)) bus2 ();
  split_linebuf #(.DATA_WIDTH(DW), .MAX_ROW_LEN(ML), .KERNEL_LENGTH(KL)) dut (
    .clk(clk), .rst(rst), .clear(clear), .cfg_row_len(cfg), .bus(bus),
    .full_flag(full), .empty_flag(empty));
  split_linebuf #(.DATA_WIDTH(DW), .MAX_ROW_LEN(ML2), .KERNEL_LENGTH(KL2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear2), .cfg_row_len(cfg2), .bus(bus2),
    .full_flag(full2), .empty_flag(empty2));
  always #5 clk = ~clk;

  function automatic int norm(input int c);
    return (c == 0 || c > ML) ? ML : c;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock of stimulus; checks the DUT, then advances the model past the coming edge
  task automatic step(input logic r, input logic c, input logic v, input logic [DW-1:0] d, input logic ordy);
    int n;
    logic rdy;
    rst = r; clear = c; bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy;
    @(negedge clk);
    rdy = !r && !c && (!exp_ov || ordy);
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_data", bus.out_data, exp_vec);
      chk("out_last", bus.out_last, exp_last);
    end
    if (exp_zero) chk("out_data_rst", bus.out_data, '0);
    chk("full_flag", full, frame.size() >= (KL - 1) * row_len);
    chk("empty_flag", empty, frame.size() == 0);
    if (r || c) begin
      frame.delete();
      row_len = norm(int'(cfg));
      exp_ov = 0;
      exp_last = 0;
      if (r) exp_zero = 1;
    end else if (v && rdy) begin
      n = frame.size();
      frame.push_back(d);
      exp_zero = 0;
      exp_ov = n >= (KL - 1) * row_len;
      if (exp_ov) begin
        for (int i = 0; i < KL - 1; i++) exp_vec[i] = frame[n - (KL - 1 - i) * row_len];
        exp_vec[KL-1] = d;
        exp_last = (n % row_len) == row_len - 1;
      end
    end else if (ordy) exp_ov = 0;
    @(posedge clk); #1;
  endtask

  // stall one cycle and compare the held vector against a literal
  task automatic peek(input logic [KL*DW-1:0] vec, input logic last);
    bus.in_valid = 0; bus.out_ready = 0;
    @(negedge clk);
    chk("peek_valid", bus.out_valid, 1'b1);
    chk("peek_data", bus.out_data, vec);
    chk("peek_last", bus.out_last, last);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [KL2-1:0][DW-1:0] ev;
    int p;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_data = 0; bus2.out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, '0);
    chk("rst_last", bus.out_last, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_k5_empty", empty2, 1'b1);
    @(posedge clk); #1;
    row_len = 32; exp_ov = 0; exp_last = 0; exp_zero = 1; exp_vec = '0;
    for (int w = 1; w <= 64; w++) step(0, 0, 1, w, 1);
    step(0, 0, 1, 65, 1);
    peek({32'd65, 32'd33, 32'd1}, 1'b0);
    for (int w = 66; w <= 96; w++) step(0, 0, 1, w, 1);
    peek({32'd96, 32'd64, 32'd32}, 1'b1);
    for (int w = 97; w <= 128; w++) step(0, 0, 1, w, 1);
    peek({32'd128, 32'd96, 32'd64}, 1'b1);
    for (int w = 129; w <= 144; w++) step(0, 0, 1, w, 1);
    repeat (5) step(0, 0, 1, 145, 0);
    for (int w = 145; w <= 160; w++) step(0, 0, 1, w, 1);
    step(0, 0, 0, 0, 1);
    for (int w = 161; w <= 170; w++) step(0, 0, 1, w, 1);
    cfg = 6'd5;
    step(0, 1, 1, 999, 1);
    cfg = 6'd7;
    for (int w = 1; w <= 11; w++) step(0, 0, 1, w, 1);
    peek({32'd11, 32'd6, 32'd1}, 1'b0);
    for (int w = 12; w <= 15; w++) step(0, 0, 1, w, 1);
    peek({32'd15, 32'd10, 32'd5}, 1'b1);
    bus2.out_ready = 1;
    for (int w = 1; w <= 41; w++) begin
      bus2.in_valid = (w <= 40); bus2.in_data = w;
      @(negedge clk);
      p = w - 1;
      chk("k5_in_ready", bus2.in_ready, 1'b1);
      chk("k5_full", full2, p >= 32);
      chk("k5_valid", bus2.out_valid, p >= 33);
      if (p >= 33) begin
        for (int i = 0; i < KL2; i++) ev[i] = p - (KL2 - 1 - i) * 8;
        chk("k5_data", bus2.out_data, ev);
        chk("k5_last", bus2.out_last, p % 8 == 0);
      end
      @(posedge clk); #1;
    end
    bus2.in_valid = 0;
    for (int k = 0; k < 2000; k++) begin
      cfg = 6'($urandom_range(0, 12));
      if ($urandom_range(0, 99) == 0) cfg = 6'($urandom_range(33, 63));
      step($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
           $urandom, $urandom_range(0, 9) < 7);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/split_linebuf.md
Name: split_linebuf

Overview:
- Parametrised successor of the kernel-row splitter. Accepts a raster pixel stream and emits one KERNEL_LENGTH-tall column vector per input word once KERNEL_LENGTH-1 full rows are stored.
- Row length is runtime-configurable up to MAX_ROW_LEN. Row buffers rotate circularly rather than cascading FIFO-to-FIFO.
- Uses a valid/ready handshake with backpressure. Sits between the DMA read stream and the convolution array.

Parameters:
- DATA_WIDTH, 32: width of one pixel word.
- MAX_ROW_LEN, 32: depth of each row bank, in words; maximum supported row length.
- KERNEL_LENGTH, 3: rows per output vector; must be >= 2. Instantiates KERNEL_LENGTH-1 banks.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous frame restart. Zeroes counters and re-latches cfg_row_len; bank contents are not cleared.
- cfg_row_len  in  $clog2(MAX_ROW_LEN+1)  row length. Sampled only in a cycle where rst or clear is high. A value of 0 or greater than MAX_ROW_LEN is treated as MAX_ROW_LEN.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_WIDTH  input pixel.
- out_valid  out  1  column vector valid.
- out_ready  in  1  downstream accepts the vector.
- out_data  out  [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0]  column vector. Index 0 is the oldest row; index KERNEL_LENGTH-1 is the current input row.
- out_last  out  1  marks the vector for the last column of a row.
- full_flag  out  1  primed: KERNEL_LENGTH-1 rows are stored.
- empty_flag  out  1  no rows stored and column counter is 0.

Behaviour:
- Reset (rst high): out_valid=0, out_data=0, out_last=0, col=0, rows_filled=0, wr_slot=0, full_flag=0, empty_flag=1. cfg_row_len is latched into row_len.
- in_ready = !rst && !clear && (!out_valid || out_ready). This is combinational and has no skid buffer.
- Accept condition: in_valid && in_ready. On accept:
  - Each bank b is read at address col. Reads are read-first: the old data is returned even if the same address is written in that cycle.
  - in_data is written into bank wr_slot at address col.
  - col increments. When col == row_len-1 it wraps to 0; in that case wr_slot advances mod (KERNEL_LENGTH-1) and rows_filled saturating-increments to KERNEL_LENGTH-1.
- Output, 1 cycle after accept:
  - Produced only if rows_filled == KERNEL_LENGTH-1 at accept time.
  - out_data[i] = old bank[(wr_slot+i) mod (KERNEL_LENGTH-1)][col] for i < KERNEL_LENGTH-1.
  - out_data[KERNEL_LENGTH-1] = in_data, registered.
  - out_last = (col == row_len-1); out_valid=1.
- Priming rows (rows_filled < KERNEL_LENGTH-1): words are stored and no output is produced. out_valid drops on the next out_ready unless a new vector is loaded.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold, banks are not read, and in_ready=0.
- Throughput: one vector per cycle when in_valid and out_ready are held high.
- clear: same-cycle effect. out_valid=0, out_last=0, col=0, rows_filled=0, wr_slot=0; row_len is re-latched. An in_valid word in that cycle is dropped.
- clear and rst together behave as rst.
- Reset or clear mid-row: the partial row is discarded and the next accepted word is column 0 of a priming row.
- full_flag = (rows_filled == KERNEL_LENGTH-1). empty_flag = (rows_filled == 0 && col == 0). Both are registered-state derived.
- Width rules: col is $clog2(MAX_ROW_LEN) bits wide; rows_filled and wr_slot are $clog2(KERNEL_LENGTH) bits wide. There is no arithmetic on data.

Decomposition:
- Package split_pkg holds:
  - default constants DATA_WIDTH_DEF, MAX_ROW_LEN_DEF, KERNEL_LENGTH_DEF;
  - a helper function for the rotated bank index (wr_slot+i) mod (KERNEL_LENGTH-1).
- Sub-module linebuf_bank: single-clock simple dual-port RAM, MAX_ROW_LEN x DATA_WIDTH.
  - Read-first, with read enable; dout holds when ren is low.
  - Instantiated KERNEL_LENGTH-1 times via generate.

Test Plan (all scenarios use defaults unless stated):
- Reset then prime: rst high with cfg_row_len=32, then stream 1..64 with out_ready=1 -> out_valid stays 0, full_flag=1 after word 64, empty_flag=0 after word 1.
- Third row: stream 65..96 -> the first vector is {1,33,65} (index 0..2) one cycle after accepting 65. The vector for 96 is {32,64,96} with out_last=1. There are 32 vectors and no gaps.
- Rotation wrap: stream 97..128 -> vectors {33,65,97} through {64,96,128}, confirming oldest-first ordering after wr_slot wraps.
- Backpressure: hold out_ready=0 for 5 cycles mid-row 4 -> in_ready=0, out_data is stable; on release, the next vector follows with no word lost or duplicated.
- Runtime length and clear: assert clear with cfg_row_len=5 mid-row, then stream 1..15 -> the first vector is {1,6,11}, out_last fires on 15, and the word presented with clear is dropped.
- KERNEL_LENGTH=5, MAX_ROW_LEN=8, cfg_row_len=0: stream 1..40 -> the first vector is {1,9,17,25,33}; full_flag rises after word 32.
